// File: rtl/ser_win_arb_pkg.sv
// Shared types and window-decode constants for the serial-window arbiter.
package ser_win_pkg;

  localparam int unsigned BA_W  = 10;
  localparam int unsigned CNT_W = 4;

  // Device window: BA13 must be 0 and BA12 must be 1.
  localparam logic WIN_BA13 = 1'b0;
  localparam logic WIN_BA12 = 1'b1;

  typedef logic [BA_W-1:0] bus_addr_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic win_hit(input bus_addr_t a);
    return (a[BA_W-1] == WIN_BA13) && (a[BA_W-2] == WIN_BA12);
  endfunction

endpackage

// File: rtl/ser_win_arb_if.sv
// Requester and device-side signal bundle for ser_win_arb.
interface ser_win_arb_if;
  import ser_win_pkg::*;

  logic      cpu_req;
  bus_addr_t cpu_ba;
  logic      cpu_rw;
  logic      dma_req;
  bus_addr_t dma_ba;
  logic      dma_rw;
  logic      cpu_gnt;
  logic      dma_gnt;
  logic      cpu_done;
  logic      dma_done;
  logic      err;
  logic      sser_n;
  bus_addr_t ba;
  logic      br_w;
  logic      sdrd_oe;

  modport master (
    output cpu_req, cpu_ba, cpu_rw, dma_req, dma_ba, dma_rw,
    input  cpu_gnt, dma_gnt, cpu_done, dma_done, err, sser_n, ba, br_w, sdrd_oe
  );

  modport slave (
    input  cpu_req, cpu_ba, cpu_rw, dma_req, dma_ba, dma_rw,
    output cpu_gnt, dma_gnt, cpu_done, dma_done, err, sser_n, ba, br_w, sdrd_oe
  );

endinterface

// File: rtl/ser_win_timer.sv
// Saturating down-counter timing the strobe and hold phases.
module ser_win_timer
  import ser_win_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire_c,
  output logic             expire_nxt_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins; otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c     = (cnt_q == CNT_W'(1));
  assign expire_nxt_c = (cnt_d == CNT_W'(1));

endmodule

// File: rtl/ser_win_arb.sv
// CPU/DMA arbiter for a strobed serial-device window.
// Define SER_WIN_ARB_FAIR_EN for round-robin on simultaneous requests (default: CPU priority).
module ser_win_arb
  import ser_win_pkg::*;
#(
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic          clk,
  input  logic          rst,
  ser_win_arb_if.slave  bus
);

  state_t     state_q, state_d;
  bus_addr_t  ba_q, ba_d;
  logic       rw_q, rw_d;
  logic       own_dma_q, own_dma_d;
  logic       any_req_c;
  logic       win_dma_c;
  logic       tmr_load_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic       tmr_exp_c;
  logic       tmr_exp_nxt_c;

  logic cpu_gnt_q, dma_gnt_q, cpu_done_q, dma_done_q, err_q, sser_n_q, sdrd_oe_q;

  assign any_req_c = bus.cpu_req | bus.dma_req;

`ifdef SER_WIN_ARB_FAIR_EN
  // own_dma_q doubles as the last-winner record between transfers.
  assign win_dma_c = bus.dma_req & (~bus.cpu_req | ~own_dma_q);
`else
  assign win_dma_c = ~bus.cpu_req;
`endif

  ser_win_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .load         (tmr_load_c),
    .load_val     (tmr_val_c),
    .expire_c     (tmr_exp_c),
    .expire_nxt_c (tmr_exp_nxt_c)
  );

  always_comb begin
    state_d    = state_q;
    ba_d       = ba_q;
    rw_d       = rw_q;
    own_dma_d  = own_dma_q;
    tmr_load_c = 1'b0;
    tmr_val_c  = CNT_W'(STROBE_CYC);
    unique case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d   = SETUP;
          own_dma_d = win_dma_c;
          ba_d      = win_dma_c ? bus.dma_ba : bus.cpu_ba;
          rw_d      = win_dma_c ? bus.dma_rw : bus.cpu_rw;
        end
      end
      SETUP: begin
        if (win_hit(ba_q)) begin
          state_d    = STROBE;
          tmr_load_c = 1'b1;
          tmr_val_c  = CNT_W'(STROBE_CYC);
        end else begin
          state_d = DONE;
        end
      end
      STROBE: begin
        if (tmr_exp_c) begin
          if (HOLD_CYC == 0) begin
            state_d = DONE;
          end else begin
            state_d    = HOLD;
            tmr_load_c = 1'b1;
            tmr_val_c  = CNT_W'(HOLD_CYC);
          end
        end
      end
      HOLD: begin
        if (tmr_exp_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        ba_d    = '0;
        rw_d    = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ba_d    = '0;
        rw_d    = 1'b1;
      end
    endcase
  end

  // Outputs are registered from next-state so they align with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ba_q       <= '0;
      rw_q       <= 1'b1;
      own_dma_q  <= 1'b1;
      cpu_gnt_q  <= 1'b0;
      dma_gnt_q  <= 1'b0;
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      err_q      <= 1'b0;
      sser_n_q   <= 1'b1;
      sdrd_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ba_q       <= ba_d;
      rw_q       <= rw_d;
      own_dma_q  <= own_dma_d;
      cpu_gnt_q  <= (state_d != IDLE) & ~own_dma_d;
      dma_gnt_q  <= (state_d != IDLE) &  own_dma_d;
      cpu_done_q <= (state_d == DONE) & ~own_dma_d;
      dma_done_q <= (state_d == DONE) &  own_dma_d;
      err_q      <= (state_d == DONE) & (state_q == SETUP);
      sser_n_q   <= (state_d != STROBE);
      sdrd_oe_q  <= (state_d == STROBE) & tmr_exp_nxt_c & rw_d;
    end
  end

  assign bus.cpu_gnt  = cpu_gnt_q;
  assign bus.dma_gnt  = dma_gnt_q;
  assign bus.cpu_done = cpu_done_q;
  assign bus.dma_done = dma_done_q;
  assign bus.err      = err_q;
  assign bus.sser_n   = sser_n_q;
  assign bus.ba       = ba_q;
  assign bus.br_w     = rw_q;
  assign bus.sdrd_oe  = sdrd_oe_q;

endmodule

// File: tb/tb_ser_win_arb.sv
// Scoreboard bench for ser_win_arb: default instance plus a STROBE_CYC=1/HOLD_CYC=0 instance.
module tb_ser_win_arb;

  logic clk;
  logic rst;

  ser_win_arb_if bus ();
  ser_win_arb_if bus2 ();

  ser_win_arb dut (.clk(clk), .rst(rst), .bus(bus));
  ser_win_arb #(.STROBE_CYC(1), .HOLD_CYC(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         dma;
    bit         err;
    int         done_cyc;
    int         oe_cyc;
    int         strb_n;
    logic [9:0] ba;
  } exp_t;

  typedef struct packed {
    logic       cg, dg, cd, dd, er, sn, oe, bw;
    logic [9:0] ba;
  } obs_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  obs_t idle_o;

  function automatic obs_t get_obs(input bit s2);
    obs_t o;
    if (s2) o = {bus2.cpu_gnt, bus2.dma_gnt, bus2.cpu_done, bus2.dma_done, bus2.err,
                 bus2.sser_n, bus2.sdrd_oe, bus2.br_w, bus2.ba};
    else    o = {bus.cpu_gnt, bus.dma_gnt, bus.cpu_done, bus.dma_done, bus.err,
                 bus.sser_n, bus.sdrd_oe, bus.br_w, bus.ba};
    return o;
  endfunction

  task automatic drive(input bit s2, input bit cr, input logic [9:0] cba, input bit crw,
                       input bit dr, input logic [9:0] dba, input bit drw);
    if (s2) begin
      bus2.cpu_req = cr; bus2.cpu_ba = cba; bus2.cpu_rw = crw;
      bus2.dma_req = dr; bus2.dma_ba = dba; bus2.dma_rw = drw;
    end else begin
      bus.cpu_req = cr; bus.cpu_ba = cba; bus.cpu_rw = crw;
      bus.dma_req = dr; bus.dma_ba = dba; bus.dma_rw = drw;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    drive(0, 0, '0, 1, 0, '0, 1);
    drive(1, 0, '0, 1, 0, '0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = get_obs(0);
    vectors++;
    if (o !== idle_o) begin miscompares++; $display("FAIL reset_dut got %h want %h", o, idle_o); end
    o = get_obs(1);
    vectors++;
    if (o !== idle_o) begin miscompares++; $display("FAIL reset_dut2 got %h want %h", o, idle_o); end
    rst = 1'b0;
    @(negedge clk);
    o = get_obs(0);
    vectors++;
    if (o !== idle_o) begin miscompares++; $display("FAIL post_reset_idle got %h want %h", o, idle_o); end
  endtask

  // One single-requester transfer; perturb changes the requester's inputs and drops req after grant.
  task automatic run_xfer(input string nm, input bit s2, input bit dma, input logic [9:0] a,
                          input bit rw, input int sc, input int hc, input bit perturb);
    exp_t e;
    obs_t o;
    int   gcyc, scnt, ocyc, ocnt, dcyc;
    bit   derr, dual, babad, otherd, got;
    e.dma      = dma;
    e.err      = !(a[9] == 1'b0 && a[8] == 1'b1);
    e.done_cyc = e.err ? 2 : 2 + sc + hc;
    e.oe_cyc   = (!e.err && rw) ? 1 + sc : -1;
    e.strb_n   = e.err ? 0 : sc;
    e.ba       = a;
    exp_q.push_back(e);
    gcyc = -1; scnt = 0; ocyc = -1; ocnt = 0; dcyc = -1;
    derr = 0; dual = 0; babad = 0; otherd = 0; got = 0;
    @(posedge clk); #1;
    if (dma) drive(s2, 0, '0, 1, 1, a, rw);
    else     drive(s2, 1, a, rw, 0, '0, 1);
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge clk);
      o = get_obs(s2);
      if (perturb && cyc == 1) begin
        if (dma) drive(s2, 0, '0, 1, 0, ~a, !rw);
        else     drive(s2, 0, ~a, !rw, 0, '0, 1);
      end
      if (o.cg && o.dg) dual = 1;
      if (dma ? o.cg : o.dg) dual = 1;
      if ((dma ? o.dg : o.cg) && gcyc < 0) gcyc = cyc;
      if (!o.sn) scnt++;
      if (o.oe) begin ocyc = cyc; ocnt++; end
      if (cyc >= 1 && (o.ba !== a || o.bw !== rw)) babad = 1;
      if (dma ? o.cd : o.dd) otherd = 1;
      if (dma ? o.dd : o.cd) begin dcyc = cyc; derr = o.er; got = 1; end
    end
    drive(s2, 0, '0, 1, 0, '0, 1);
    e = exp_q.pop_front();
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL %s timeout got no done want done at %0d", nm, e.done_cyc);
      return;
    end
    vectors++;
    if (gcyc !== 1) begin miscompares++; $display("FAIL %s gnt_cyc got %0d want 1", nm, gcyc); end
    vectors++;
    if (scnt !== e.strb_n) begin miscompares++; $display("FAIL %s strobe_clks got %0d want %0d", nm, scnt, e.strb_n); end
    vectors++;
    if (ocyc !== e.oe_cyc || ocnt !== (e.oe_cyc >= 0 ? 1 : 0)) begin
      miscompares++; $display("FAIL %s sdrd_oe cyc/cnt got %0d/%0d want %0d", nm, ocyc, ocnt, e.oe_cyc);
    end
    vectors++;
    if (dcyc !== e.done_cyc) begin miscompares++; $display("FAIL %s done_cyc got %0d want %0d", nm, dcyc, e.done_cyc); end
    vectors++;
    if (derr !== e.err) begin miscompares++; $display("FAIL %s err got %0b want %0b", nm, derr, e.err); end
    vectors++;
    if (babad !== 1'b0) begin miscompares++; $display("FAIL %s latched ba/br_w got unstable want %h", nm, e.ba); end
    vectors++;
    if (dual !== 1'b0 || otherd !== 1'b0) begin
      miscompares++; $display("FAIL %s wrong owner got gnt=%0b done=%0b want 0", nm, dual, otherd);
    end
    @(negedge clk);
    o = get_obs(s2);
    vectors++;
    if (o !== idle_o) begin miscompares++; $display("FAIL %s idle_after got %h want %h", nm, o, idle_o); end
  endtask

  task automatic test_cpu_read();
    run_xfer("cpu_read_100", 0, 0, 10'h100, 1, 3, 1, 0);
  endtask

  task automatic test_dma_err();
    run_xfer("dma_write_300", 0, 1, 10'h300, 0, 3, 1, 0);
  endtask

  task automatic test_dma_write();
    run_xfer("dma_write_1a5", 0, 1, 10'h1A5, 0, 3, 1, 0);
    run_xfer("cpu_err_0ff", 0, 0, 10'h0FF, 1, 3, 1, 0);
  endtask

  task automatic test_latch();
    run_xfer("latch_s1h0", 1, 0, 10'h155, 1, 1, 0, 1);
    run_xfer("dma_s1h0", 1, 1, 10'h1F0, 0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    obs_t o;
    bit   fair, dual;
    bit   who [2];
    int   dc [2];
    int   k;
`ifdef SER_WIN_ARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    e.err = 0; e.done_cyc = 6; e.oe_cyc = 4; e.strb_n = 3; e.ba = 10'h100;
    e.dma = 1'b0; exp_q.push_back(e);
    e.dma = fair; exp_q.push_back(e);
    k = 0; dual = 0; who[0] = 0; who[1] = 0; dc[0] = -1; dc[1] = -1;
    @(posedge clk); #1;
    drive(0, 1, 10'h100, 1, 1, 10'h100, 1);
    for (int cyc = 0; cyc < 60 && k < 2; cyc++) begin
      @(negedge clk);
      o = get_obs(0);
      if (o.cg && o.dg) dual = 1;
      if (o.cd || o.dd) begin who[k] = o.dd; dc[k] = cyc; k++; end
    end
    drive(0, 0, '0, 1, 0, '0, 1);
    vectors++;
    if (k < 2) begin
      miscompares++; $display("FAIL arb timeout got %0d dones want 2", k);
      exp_q.delete();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (who[i] !== e.dma) begin miscompares++; $display("FAIL arb_winner%0d got dma=%0b want dma=%0b", i, who[i], e.dma); end
    end
    vectors++;
    if (dc[0] !== 6) begin miscompares++; $display("FAIL arb_first_done got %0d want 6", dc[0]); end
    vectors++;
    if (dc[1] - dc[0] !== 7) begin miscompares++; $display("FAIL arb_gap got %0d want 7", dc[1] - dc[0]); end
    vectors++;
    if (dual !== 1'b0) begin miscompares++; $display("FAIL arb_onehot got both gnt want one"); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit   seen, sawd;
    seen = 0; sawd = 0;
    @(posedge clk); #1;
    drive(0, 1, 10'h100, 1, 0, '0, 1);
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.sser_n === 1'b0) seen = 1;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL rst_mid no strobe got sser_n=1 want 0"); end
    #2; rst = 1'b1; #1;
    o = get_obs(0);
    vectors++;
    if ({o.cg, o.dg, o.sn} !== 3'b001) begin
      miscompares++; $display("FAIL rst_mid_async got gnt/sser_n=%b want 001", {o.cg, o.dg, o.sn});
    end
    drive(0, 0, '0, 1, 0, '0, 1);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.cpu_done || bus.dma_done || bus.cpu_gnt || bus.dma_gnt) sawd = 1;
    end
    vectors++;
    if (sawd !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_done got activity want none"); end
    run_xfer("after_rst_read", 0, 0, 10'h1C3, 1, 3, 1, 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle_o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000};
    test_reset();
    test_cpu_read();
    test_dma_err();
    test_dma_write();
    test_latch();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
